// File: rtl/assoc_cache_ctrl_pkg.sv
// cache_pkg
//    Shared definitions for the set-associative data cache controller:
//    the controller state encoding, a constant-evaluable ceil(log2)
//    helper and the field widths of the default configuration
//    (2 ways, 64 sets, 32-bit addresses).
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2
   } state_t;

   // ceil(log2(value)); returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   localparam int DEF_WAYS   = 2;
   localparam int DEF_SETS   = 64;
   localparam int DEF_ADDR_W = 32;
   localparam int IDX_W      = clog2(DEF_SETS);
   localparam int TAG_W      = DEF_ADDR_W - 3 - IDX_W;
   localparam int AGE_W      = clog2(DEF_WAYS);

endpackage

// File: rtl/assoc_cache_ctrl_lru.sv
// lru_age_tracker
//    Per-set age counters implementing exact LRU ordering.  Each set holds
//    one age per way; the ages always form a permutation of 0..WAYS-1, with
//    0 = most recently used and WAYS-1 = least recently used.
// Ports
//    clk        in  system clock
//    rst        in  asynchronous reset, active-low; ages reset to way index
//    idx        in  set being looked up / touched
//    touch_way  in  way that was hit or filled
//    touch      in  strobe: apply an LRU update for touch_way in set idx
//    victim     out way whose age is WAYS-1 in set idx
module lru_age_tracker
   import cache_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int SETS = 64,
   localparam int IDX_BITS = clog2(SETS),
   localparam int WAY_BITS = (WAYS > 1) ? clog2(WAYS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] idx,
   input  logic [WAY_BITS-1:0] touch_way,
   input  logic                touch,
   output logic [WAY_BITS-1:0] victim
);

   generate
      if (WAYS > 1) begin : g_lru
         logic [WAY_BITS-1:0] age_q [SETS][WAYS];
         logic [WAY_BITS-1:0] touched_age;

         assign touched_age = age_q[idx][touch_way];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int s = 0; s < SETS; s++) begin
                  for (int w = 0; w < WAYS; w++) begin
                     age_q[s][w] <= WAY_BITS'(w);
                  end
               end
            end else if (touch) begin
               // Ways younger than the touched one age by one; the touched
               // way becomes youngest, so the permutation is preserved.
               for (int w = 0; w < WAYS; w++) begin
                  if (WAY_BITS'(w) == touch_way)
                     age_q[idx][w] <= '0;
                  else if (age_q[idx][w] < touched_age)
                     age_q[idx][w] <= age_q[idx][w] + 1'b1;
               end
            end
         end

         always_comb begin
            victim = '0;
            for (int w = 0; w < WAYS; w++) begin
               if (age_q[idx][w] == WAY_BITS'(WAYS - 1)) victim = WAY_BITS'(w);
            end
         end
      end else begin : g_direct
         // Single way: the only candidate is way 0, no ages are kept.
         logic unused_inputs;
         assign unused_inputs = clk ^ rst ^ touch ^ (^idx) ^ (^touch_way);
         assign victim = '0;
      end
   endgenerate

endmodule

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl
//    N-way set-associative data cache between the EXE/MEM pipeline register
//    and the SRAM controller.  Read hits complete in the same cycle, read
//    misses fill a 64-bit line (two words) from SRAM, stores are
//    write-through without write-allocate.  ready=0 freezes the pipeline.
// Ports
//    clk            in   system clock
//    rst            in   asynchronous reset, active-low
//    address        in   byte address from the ALU
//    wdata          in   store data
//    mem_r_en       in   load request (level, held until ready)
//    mem_w_en       in   store request (level, held until ready); wins over load
//    rdata          out  load data, valid while ready=1 and mem_r_en=1
//    ready          out  1 = idle or access completing this cycle
//    sram_address   out  line-aligned offset for reads, word offset for writes
//    sram_wdata     out  store data to SRAM
//    sram_write_en  out  SRAM write request, held until sram_ready
//    sram_read_en   out  SRAM line read request, held until sram_ready
//    sram_rdata     in   line data, [31:0] even word, [63:32] odd word
//    sram_ready     in   one-cycle pulse: SRAM access done
module assoc_cache_ctrl
   import cache_pkg::*;
#(
   parameter int WAYS     = 2,
   parameter int SETS     = 64,
   parameter int MEM_BASE = 1024,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       wdata,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic [ADDR_W-1:0] sram_address,
   output logic [31:0]       sram_wdata,
   output logic              sram_write_en,
   output logic              sram_read_en,
   input  logic [63:0]       sram_rdata,
   input  logic              sram_ready
);

   localparam int IDX_BITS = clog2(SETS);
   localparam int TAG_BITS = ADDR_W - 3 - IDX_BITS;
   localparam int WAY_BITS = (WAYS > 1) ? clog2(WAYS) : 1;

   // Address decode; addresses below MEM_BASE simply wrap.
   logic [ADDR_W-1:0]   offs;
   logic                word_sel;
   logic [IDX_BITS-1:0] set_idx;
   logic [TAG_BITS-1:0] req_tag;
   logic [1:0]          unused_offs;

   assign offs        = address - ADDR_W'(MEM_BASE);
   assign word_sel    = offs[2];
   assign set_idx     = offs[3 +: IDX_BITS];
   assign req_tag     = offs[ADDR_W-1 -: TAG_BITS];
   assign unused_offs = offs[1:0];

   // Storage
   logic                valid_q [WAYS][SETS];
   logic [TAG_BITS-1:0] tag_q   [WAYS][SETS];
   logic [63:0]         data_q  [WAYS][SETS];

   state_t state_q, state_next;

   // Lookup
   logic [WAYS-1:0]     hit_vec;
   logic                hit;
   logic [WAY_BITS-1:0] hit_way;
   logic                any_free;
   logic [WAY_BITS-1:0] free_way;
   logic [WAY_BITS-1:0] lru_victim;
   logic [WAY_BITS-1:0] fill_way;
   logic [63:0]         hit_line;

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_way
         assign hit_vec[gi] = valid_q[gi][set_idx] && (tag_q[gi][set_idx] == req_tag);
      end
   endgenerate

   always_comb begin
      hit      = |hit_vec;
      hit_way  = '0;
      any_free = 1'b0;
      free_way = '0;
      // Descending scan so the lowest-numbered match / free way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = WAY_BITS'(w);
         if (!valid_q[w][set_idx]) begin
            any_free = 1'b1;
            free_way = WAY_BITS'(w);
         end
      end
   end

   assign fill_way = any_free ? free_way : lru_victim;
   assign hit_line = data_q[hit_way][set_idx];

   // Access classification; a simultaneous load+store counts as a store.
   logic is_read, rd_hit, wr_hit, fill, touch;
   logic [WAY_BITS-1:0] touch_way;

   assign is_read   = mem_r_en && !mem_w_en;
   assign rd_hit    = (state_q == IDLE) && is_read && hit;
   assign wr_hit    = (state_q == IDLE) && mem_w_en && hit;
   assign fill      = (state_q == RD_MISS) && sram_ready;
   assign touch     = rd_hit || wr_hit || fill;
   assign touch_way = fill ? fill_way : hit_way;

   lru_age_tracker #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) u_lru (
      .clk       (clk),
      .rst       (rst),
      .idx       (set_idx),
      .touch_way (touch_way),
      .touch     (touch),
      .victim    (lru_victim)
   );

   // Next state
   always_comb begin
      state_next = state_q;
      case (state_q)
         IDLE: begin
            if (mem_w_en)                state_next = WR_THRU;
            else if (mem_r_en && !hit)   state_next = RD_MISS;
         end
         RD_MISS: if (sram_ready)        state_next = IDLE;
         WR_THRU: if (sram_ready)        state_next = IDLE;
         default:                        state_next = IDLE;
      endcase
   end

   // Pipeline-facing outputs; the fill word is forwarded straight from SRAM.
   always_comb begin
      rdata = '0;
      ready = 1'b1;
      case (state_q)
         IDLE: begin
            ready = !(mem_r_en || mem_w_en) || rd_hit;
            if (rd_hit) rdata = word_sel ? hit_line[63:32] : hit_line[31:0];
         end
         RD_MISS: begin
            ready = sram_ready;
            if (sram_ready) rdata = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
         end
         WR_THRU: ready = sram_ready;
         default: ready = 1'b1;
      endcase
   end

   // SRAM-facing outputs; enables decode from state so reset drops them at once.
   assign sram_read_en  = (state_q == RD_MISS);
   assign sram_write_en = (state_q == WR_THRU);
   assign sram_wdata    = wdata;

   always_comb begin
      sram_address = '0;
      if (state_q == RD_MISS)      sram_address = {offs[ADDR_W-1:3], 3'b000};
      else if (state_q == WR_THRU) sram_address = offs;
   end

   // State and valid bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               valid_q[w][s] <= 1'b0;
            end
         end
      end else begin
         state_q <= state_next;
         if (fill) valid_q[fill_way][set_idx] <= 1'b1;
      end
   end

   // Tag and data arrays need no reset: they are qualified by valid_q.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_q[fill_way][set_idx]  <= req_tag;
         data_q[fill_way][set_idx] <= sram_rdata;
      end else if (wr_hit) begin
         if (word_sel) data_q[hit_way][set_idx][63:32] <= wdata;
         else          data_q[hit_way][set_idx][31:0]  <= wdata;
      end
   end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
module tb_assoc_cache_ctrl;

   localparam int WAYS = 2;
   localparam int SETS = 64;
   localparam int BASE = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
   logic        mem_r_en, mem_w_en, ready;
   logic        sram_write_en, sram_read_en, sram_ready;
   logic [63:0] sram_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assoc_cache_ctrl #(
      .WAYS(WAYS), .SETS(SETS), .MEM_BASE(BASE), .ADDR_W(32)
   ) dut (
      .clk(clk), .rst(rst), .address(address), .wdata(wdata),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .rdata(rdata), .ready(ready),
      .sram_address(sram_address), .sram_wdata(sram_wdata),
      .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
      .sram_rdata(sram_rdata), .sram_ready(sram_ready)
   );

   // ---------------- memory contents ----------------
   logic [63:0] model_mem [int];   // what the reference model believes SRAM holds
   logic [63:0] sram_mem  [int];   // what the SRAM responder actually holds

   function automatic logic [63:0] init_line(input int line);
      if (line == 0) return 64'h000000BB_000000AA;
      return {32'(line) * 32'h0000_9E37 + 32'h1111, 32'(line) ^ 32'hC0DE_0000};
   endfunction

   function automatic logic [63:0] model_get(input int line);
      if (model_mem.exists(line)) return model_mem[line];
      return init_line(line);
   endfunction

   function automatic logic [63:0] sram_get(input int line);
      if (sram_mem.exists(line)) return sram_mem[line];
      return init_line(line);
   endfunction

   // ---------------- reference model: LRU by last-use timestamp ----------------
   bit          m_valid [SETS][WAYS];
   int          m_tag   [SETS][WAYS];
   logic [63:0] m_data  [SETS][WAYS];
   longint      m_stamp [SETS][WAYS];
   longint      now_t = 0;

   task automatic model_reset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
   endtask

   task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               output bit hit, output logic [31:0] rd);
      int off, line, set, tag, way, wsel;
      logic [63:0] ln;
      off  = int'(addr) - BASE;
      line = off / 8;
      set  = line % SETS;
      tag  = line / SETS;
      wsel = (off / 4) % 2;
      now_t++;
      hit = 0;
      way = -1;
      rd  = '0;
      for (int i = 0; i < WAYS; i++)
         if (m_valid[set][i] && m_tag[set][i] == tag) begin hit = 1; way = i; end
      if (wr) begin
         ln = model_get(line);
         if (wsel == 1) ln[63:32] = data; else ln[31:0] = data;
         model_mem[line] = ln;
         if (hit) begin
            if (wsel == 1) m_data[set][way][63:32] = data; else m_data[set][way][31:0] = data;
            m_stamp[set][way] = now_t;
         end
      end else begin
         if (!hit) begin
            for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[set][i]) way = i;
            if (way < 0) begin
               way = 0;
               for (int i = 1; i < WAYS; i++) if (m_stamp[set][i] < m_stamp[set][way]) way = i;
            end
            m_valid[set][way] = 1;
            m_tag[set][way]   = tag;
            m_data[set][way]  = model_get(line);
         end
         m_stamp[set][way] = now_t;
         ln = m_data[set][way];
         rd = (wsel == 1) ? ln[63:32] : ln[31:0];
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      bit          wr;
      bit          hit;
      logic [31:0] data;
      logic [31:0] addr;
   } exp_t;

   exp_t        exp_q[$];
   int          done_cnt = 0;
   logic [31:0] cur_addr = '0;
   logic [31:0] cur_wdata = '0;
   bit          sram_mute = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] data);
      bit          hit;
      logic [31:0] rd;
      exp_t        e;
      int          start, n;
      model_access(wr, addr, data, hit, rd);
      e.wr = wr; e.hit = hit && !wr; e.data = rd; e.addr = addr;
      exp_q.push_back(e);
      cur_addr  = addr;
      cur_wdata = data;
      address   = addr;
      wdata     = data;
      mem_w_en  = wr;
      mem_r_en  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (done_cnt == start) begin
         checks++; errors++;
         $display("FAIL timeout addr=%h wr=%0b got=no_ready want=ready", addr, wr);
         exp_q.delete();
      end
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
   endtask

   // Monitor: pops an expectation whenever the DUT completes an access.
   int   lat = 0;
   exp_t me;
   always @(negedge clk) begin
      if (!rst || !(mem_r_en || mem_w_en)) begin
         lat = 0;
      end else if (ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready addr=%h got=ready want=no_pending", address);
         end else begin
            me = exp_q.pop_front();
            checks++;
            if (me.hit ? (lat != 0) : (lat == 0)) begin
               errors++;
               $display("FAIL latency addr=%h wr=%0b got_wait=%0d want_hit=%0b", me.addr, me.wr, lat, me.hit);
            end
            if (!me.wr) begin
               checks++;
               if (rdata !== me.data) begin
                  errors++;
                  $display("FAIL rdata addr=%h got=%h want=%h", me.addr, rdata, me.data);
               end
            end
            if (me.hit) begin
               checks++;
               if (sram_read_en !== 1'b0 || sram_write_en !== 1'b0) begin
                  errors++;
                  $display("FAIL hit_sram_idle addr=%h got=%0b%0b want=00", me.addr, sram_read_en, sram_write_en);
               end
            end
            $display("txn addr=%h wr=%0b hit=%0b wait=%0d rdata=%h", me.addr, me.wr, me.hit, lat, rdata);
         end
         lat = 0;
         done_cnt++;
      end else begin
         lat++;
      end
   end

   // SRAM responder: checks the request, then pulses sram_ready after a random delay.
   initial begin
      int          line;
      bit          is_rd;
      logic [31:0] exp_a;
      logic [63:0] ln;
      sram_ready = 1'b0;
      sram_rdata = '0;
      forever begin
         @(negedge clk);
         if (!sram_mute && rst && (sram_read_en || sram_write_en)) begin
            is_rd = sram_read_en;
            line  = int'(sram_address >> 3);
            if (is_rd) begin
               exp_a = (cur_addr - 32'd1024) & ~32'd7;
               chk("sram_rd_addr", 64'(sram_address), 64'(exp_a));
            end else begin
               exp_a = cur_addr - 32'd1024;
               chk("sram_wr_addr", 64'(sram_address), 64'(exp_a));
               chk("sram_wdata", 64'(sram_wdata), 64'(cur_wdata));
               ln = sram_get(line);
               if (sram_address[2]) ln[63:32] = sram_wdata; else ln[31:0] = sram_wdata;
               sram_mem[line] = ln;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            sram_ready = 1'b1;
            sram_rdata = is_rd ? sram_get(line) : {$urandom, $urandom};
            @(posedge clk); #1;
            sram_ready = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      bit wr;
      logic [31:0] addr;
      rst      = 1'b0;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      address  = '0;
      wdata    = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 64'(ready), 64'd1);
      chk("reset_rd_en", 64'(sram_read_en), 64'd0);
      chk("reset_wr_en", 64'(sram_write_en), 64'd0);
      chk("reset_rdata", 64'(rdata), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed sequence (same-set stride 512 B)
      do_access(0, 1024, 0);
      do_access(0, 1028, 0);
      do_access(0, 1536, 0);
      do_access(0, 1024, 0);
      do_access(0, 2048, 0);
      do_access(0, 1024, 0);
      do_access(0, 1536, 0);
      do_access(1, 1024, 32'h55);
      do_access(0, 1024, 0);
      do_access(1, 3000, 32'hDEAD_BEEF);
      do_access(0, 3000, 0);

      // Randomised traffic concentrated on a few sets to force evictions
      repeat (400) begin
         wr   = ($urandom_range(0, 3) == 0);
         addr = 32'(BASE + $urandom_range(0, 3) * 512 + $urandom_range(0, 3) * 8 + $urandom_range(0, 1) * 4);
         do_access(wr, addr, $urandom);
      end

      // Reset in the middle of a read miss
      sram_mute = 1;
      address   = 32'd5672;
      mem_r_en  = 1'b1;
      n = 0;
      while (!sram_read_en && n < 10) begin @(posedge clk); #1; n++; end
      chk("miss_started", 64'(sram_read_en), 64'd1);
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      chk("rst_abort_rd_en", 64'(sram_read_en), 64'd0);
      mem_r_en = 1'b0;
      #1;
      chk("rst_ready_idle", 64'(ready), 64'd1);
      model_reset();
      @(posedge clk); #1;
      rst        = 1'b1;
      sram_ready = 1'b1;
      sram_rdata = 64'hFFFF_0000_FFFF_0000;
      @(negedge clk);
      chk("late_ready_ready", 64'(ready), 64'd1);
      chk("late_ready_rdata", 64'(rdata), 64'd0);
      @(posedge clk); #1;
      sram_ready = 1'b0;
      @(negedge clk);
      chk("late_ready_state", 64'({sram_read_en, sram_write_en}), 64'd0);
      @(posedge clk); #1;
      sram_mute = 0;
      do_access(0, 1028, 0);
      do_access(0, 1024, 0);

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
